// File: rtl/lut_mult_pkg.sv
// Shared types and constants for the radix-4 sequential multiplier.
// Contents: FSM state encoding, radix-4 digit width, digit-code constants.
package lut_mult_pkg;

   // Controller states, 2-bit encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Multiplier bits consumed per cycle
   localparam int unsigned DIGIT_BITS = 2;

   // Radix-4 digit codes
   localparam logic [DIGIT_BITS-1:0] D0 = 2'd0;
   localparam logic [DIGIT_BITS-1:0] D1 = 2'd1;
   localparam logic [DIGIT_BITS-1:0] D2 = 2'd2;
   localparam logic [DIGIT_BITS-1:0] D3 = 2'd3;

endpackage

// File: rtl/lut_pp_gen.sv
// Partial-product selector: returns digit*a for one radix-4 digit.
// Ports:
//   digit  in  DIGIT_BITS  radix-4 digit of the multiplier
//   a      in  WIDTH       multiplicand
//   pp     out WIDTH+2     digit*a (combinational)
module lut_pp_gen
   import lut_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [DIGIT_BITS-1:0] digit,
   input  logic [WIDTH-1:0]      a,
   output logic [WIDTH+1:0]      pp
);

   localparam int unsigned PPW = WIDTH + 2;

   logic [PPW-1:0] a_ext;

   assign a_ext = PPW'(a);

   // Lookup of 0, a, 2a, 3a
   always_comb begin
      pp = 'x;
      case (digit)
         D0:      pp = '0;
         D1:      pp = a_ext;
         D2:      pp = a_ext << 1;
         D3:      pp = (a_ext << 1) + a_ext;
         default: pp = 'x;
      endcase
   end

endmodule

// File: rtl/lut_seq_mult.sv
// Sequential radix-4 unsigned multiplier, WIDTH/2 cycles per product.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operands offered
//   in_ready   out  block can accept operands (IDLE and not in reset)
//   a, b       in   WIDTH-bit unsigned operands
//   acc_clr    in   only with LUT_SEQ_MULT_ACC_EN: 1 = start from 0,
//                   0 = add a*b onto the previous product (mod 2^(2*WIDTH))
//   out_valid  out  product available
//   out_ready  in   consumer accepts product
//   product    out  2*WIDTH-bit result, held until the next completion
//   busy       out  controller not in IDLE
// Build option: define LUT_SEQ_MULT_ACC_EN to enable product accumulation.
module lut_seq_mult
   import lut_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
`ifdef LUT_SEQ_MULT_ACC_EN
   input  logic                 acc_clr,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int unsigned NDIG  = WIDTH / 2;
   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned PPW   = WIDTH + 2;
   localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   // Reject odd or too-narrow operand widths at elaboration
   if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("lut_seq_mult: WIDTH must be even and >= 4");
   end

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [PW-1:0]      acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]      product_q, product_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q;

   logic [PPW-1:0]     pp;
   logic [CNT_W:0]     shamt;
   logic [PW-1:0]      acc_sum;
   logic [PW-1:0]      acc_start;

   lut_pp_gen #(
      .WIDTH (WIDTH)
   ) u_pp_gen (
      .digit (b_q[DIGIT_BITS-1:0]),
      .a     (a_q),
      .pp    (pp)
   );

   // Digit cnt carries weight 4^cnt, i.e. a left shift by 2*cnt
   assign shamt   = {cnt_q, 1'b0};
   assign acc_sum = acc_q + (PW'(pp) << shamt);

   // Starting accumulator value for a new operation
`ifdef LUT_SEQ_MULT_ACC_EN
   assign acc_start = acc_clr ? '0 : product_q;
`else
   assign acc_start = '0;
`endif

   // Input side is ready only in IDLE and never while reset is asserted
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign product   = product_q;
   assign busy      = busy_q;

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      product_d   = product_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               a_d     = a;
               b_d     = b;
               acc_d   = acc_start;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            acc_d = acc_sum;
            b_d   = b_q >> DIGIT_BITS;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NDIG - 1)) begin
               product_d   = acc_sum;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         product_q   <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         product_q   <= product_d;
         out_valid_q <= out_valid_d;
         busy_q      <= (state_d != IDLE);
      end
   end

endmodule
